// File: rtl/amplitude_phase_sweep.sv
// Phase-shift read-modify-write sweep over amplitude RAM port 3.
// Optional AMP_ZERO_SKIP_EN: skip writes of all-zero words, count nonzero ones.
module amplitude_phase_sweep #(
  parameter int num_qubit   = 3,
  parameter int complex_bit = 24,
  parameter int fp_bit      = 22,
  parameter int mem_width   = 2*complex_bit
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [1:0]             phase,
  input  logic [num_qubit:0]     count,
  input  logic                   stall,
  input  logic [mem_width-1:0]   read_amplitude,
  output logic                   rd_enable3,
  output logic [num_qubit-1:0]   rd_address3,
  output logic                   wr_enable3,
  output logic [num_qubit-1:0]   wr_address3,
  output logic [mem_width-1:0]   write_amplitude3,
  output logic                   busy,
  output logic                   done
`ifdef AMP_ZERO_SKIP_EN
  ,
  output logic [num_qubit:0]     nonzero_count
`endif
);

  if (fp_bit >= complex_bit) begin : g_bad_fmt
    $error("fp_bit must be below complex_bit");
  end

  localparam logic [complex_bit-1:0] MIN =
    {1'b1, {(complex_bit-1){1'b0}}};
  localparam logic [complex_bit-1:0] MAX =
    {1'b0, {(complex_bit-1){1'b1}}};

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPT,
    WRITE,
    DONE
  } state_t;

  state_t                 state;
  state_t                 state_n;
  logic [num_qubit:0]     ptr;
  logic [num_qubit:0]     ptr_n;
  logic [num_qubit:0]     cnt_q;
  logic [1:0]             ph_q;
  logic [mem_width-1:0]   data_q;
  logic                   done_n;
  logic                   rd_en;
  logic                   wr_en;
  logic                   last;
  logic                   zero;
  logic                   accept;
  logic                   adv;

  logic [complex_bit-1:0] re;
  logic [complex_bit-1:0] im;
  logic [complex_bit-1:0] rot_re;
  logic [complex_bit-1:0] rot_im;
  logic [3:0]             ph_oh;

  function automatic logic [complex_bit-1:0] sat_neg(
    input logic [complex_bit-1:0] x
  );
    logic [complex_bit-1:0] r;
    if (x == MIN) r = MAX;
    else          r = -x;
    return r;
  endfunction

  assign last   = (ptr == cnt_q - 1'b1);
  assign accept = (state == IDLE) && start;

`ifdef AMP_ZERO_SKIP_EN
  assign zero = (data_q == '0);
`else
  assign zero = 1'b0;
`endif

  // A zero word is dropped without waiting for the RAM.
  assign adv = (state == WRITE) && (zero || !stall);

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    done_n  = 1'b0;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    busy    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          ptr_n = '0;
          if (count == '0) done_n  = 1'b1;
          else             state_n = READ;
        end
      end
      READ: begin
        busy = 1'b1;
        if (!stall) begin
          rd_en   = 1'b1;
          state_n = CAPT;
        end
      end
      CAPT: begin
        busy    = 1'b1;
        state_n = WRITE;
      end
      WRITE: begin
        busy = 1'b1;
        if (adv) begin
          wr_en = !zero;
          if (last) begin
            state_n = DONE;
          end else begin
            ptr_n   = ptr + 1'b1;
            state_n = READ;
          end
        end
      end
      DONE: begin
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      done  <= done_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q  <= '0;
      cnt_q <= '0;
    end else if (accept && count != '0) begin
      ph_q  <= phase;
      cnt_q <= count;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (state == CAPT) begin
      data_q <= read_amplitude;
    end
  end

`ifdef AMP_ZERO_SKIP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nonzero_count <= '0;
    end else if (accept) begin
      nonzero_count <= '0;
    end else if (adv && !zero) begin
      nonzero_count <= nonzero_count + 1'b1;
    end
  end
`endif

  assign re    = data_q[mem_width-1 -: complex_bit];
  assign im    = data_q[complex_bit-1:0];
  assign ph_oh = 4'b0001 << ph_q;

  always_comb begin
    rot_re = re;
    rot_im = im;
    unique case (1'b1)
      ph_oh[0]: begin
        rot_re = re;
        rot_im = im;
      end
      ph_oh[1]: begin
        rot_re = sat_neg(im);
        rot_im = re;
      end
      ph_oh[2]: begin
        rot_re = sat_neg(re);
        rot_im = sat_neg(im);
      end
      ph_oh[3]: begin
        rot_re = im;
        rot_im = sat_neg(re);
      end
      default: begin
        rot_re = re;
        rot_im = im;
      end
    endcase
  end

  always_comb begin
    rd_enable3       = rd_en;
    rd_address3      = '0;
    wr_enable3       = wr_en;
    wr_address3      = '0;
    write_amplitude3 = '0;
    if (rd_en) rd_address3 = ptr[num_qubit-1:0];
    if (wr_en) begin
      wr_address3      = ptr[num_qubit-1:0];
      write_amplitude3 = {rot_re, rot_im};
    end
  end

endmodule

// File: tb/tb_amplitude_phase_sweep.sv
// Bench for amplitude_phase_sweep: RAM model, write scoreboard, vector table.
// Define AMP_ZERO_SKIP_EN to also exercise the zero-skip build.
module tb_amplitude_phase_sweep;

  localparam int NQ    = 3;
  localparam int CB    = 24;
  localparam int MW    = 48;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic [1:0]    phase = '0;
  logic [NQ:0]   count = '0;
  logic [MW-1:0] read_amplitude;
  logic          rd_enable3;
  logic [NQ-1:0] rd_address3;
  logic          wr_enable3;
  logic [NQ-1:0] wr_address3;
  logic [MW-1:0] write_amplitude3;
  logic          busy;
  logic          done;
`ifdef AMP_ZERO_SKIP_EN
  logic [NQ:0]   nonzero_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  amplitude_phase_sweep dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .phase            (phase),
    .count            (count),
    .stall            (stall),
    .read_amplitude   (read_amplitude),
    .rd_enable3       (rd_enable3),
    .rd_address3      (rd_address3),
    .wr_enable3       (wr_enable3),
    .wr_address3      (wr_address3),
    .write_amplitude3 (write_amplitude3),
    .busy             (busy),
`ifdef AMP_ZERO_SKIP_EN
    .nonzero_count    (nonzero_count),
`endif
    .done             (done)
  );

  logic [MW-1:0] mem [DEPTH];
  logic [MW-1:0] rdata;
  logic          ld_en = 1'b0;
  logic [NQ-1:0] ld_addr = '0;
  logic [MW-1:0] ld_data = '0;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (wr_enable3) mem[wr_address3] <= write_amplitude3;
    if (rd_enable3) rdata <= mem[rd_address3];
  end
  assign read_amplitude = rdata;

  typedef struct {
    logic [NQ-1:0] a;
    logic [MW-1:0] d;
  } wr_t;
  wr_t sb[$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int clamp(input int v);
    int lo = -(1 << (CB-1));
    int hi = (1 << (CB-1)) - 1;
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic logic [MW-1:0] rot_ref(input logic [1:0] ph,
                                            input logic [MW-1:0] w);
    int re;
    int im;
    int nr;
    int ni;
    logic [31:0] r32;
    logic [31:0] i32;
    re = int'($signed(w[MW-1 -: CB]));
    im = int'($signed(w[CB-1:0]));
    case (ph)
      2'd0: begin nr = re;  ni = im;  end
      2'd1: begin nr = -im; ni = re;  end
      2'd2: begin nr = -re; ni = -im; end
      default: begin nr = im; ni = -re; end
    endcase
    r32 = clamp(nr);
    i32 = clamp(ni);
    return {r32[CB-1:0], i32[CB-1:0]};
  endfunction

  always @(negedge clk) begin
    wr_t e;
    if (rst_n) begin
      chk("excl_enables", {63'd0, rd_enable3 & wr_enable3}, 0);
      if (stall)
        chk("stall_quiet", {62'd0, rd_enable3, wr_enable3}, 0);
      if (!rd_enable3) chk("rd_addr_idle", {61'd0, rd_address3}, 0);
      if (!wr_enable3)
        chk("wr_idle", {13'd0, wr_address3, write_amplitude3}, 0);
      if (wr_enable3) begin
        if (sb.size() == 0) begin
          chk("unexpected_write", {61'd0, wr_address3}, 64'hFFFF);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", {61'd0, wr_address3}, {61'd0, e.a});
          chk("wr_data", {16'd0, write_amplitude3}, {16'd0, e.d});
        end
      end
    end
  end

  task automatic load(input int pat);
    logic [MW-1:0] w;
    for (int k = 0; k < DEPTH; k++) begin
      w = {$urandom, $urandom};
      case (pat)
        0: w = {CB'(k << 22), CB'(-(k << 22))};
        1: if (k == 0) w = {24'h400000, 24'h000000};
        2: w = {24'h800000, 24'h000000};
        4: begin
          if (k == 0) w = {24'h400000, 24'h0};
          if (k == 1 || k == 2) w = '0;
          if (k == 3) w = {24'hC00000, 24'h0};
        end
        default: ;
      endcase
      ld_en   = 1'b1;
      ld_addr = NQ'(k);
      ld_data = w;
      @(posedge clk);
      #1;
    end
    ld_en = 1'b0;
  endtask

  function automatic logic stall_at(input bit st, input int c);
    return st && ((c >= 1 && c <= 4) || (c >= 7 && c <= 9));
  endfunction

  task automatic run(input logic [1:0] ph, input logic [NQ:0] cn,
                     input bit st, input int extra, output int lat);
    wr_t e;
    int  cyc;
    for (int k = 0; k < int'(cn); k++) begin
`ifdef AMP_ZERO_SKIP_EN
      if (mem[k] == '0) continue;
`endif
      e.a = NQ'(k);
      e.d = rot_ref(ph, mem[k]);
      sb.push_back(e);
    end
    phase = ph;
    count = cn;
    start = 1'b1;
    @(posedge clk);
    #1;
    cyc = 1;
    lat = -1;
    stall = stall_at(st, cyc);
    while (cyc < 200) begin
      if (cyc == extra) begin
        start = 1'b1;
        phase = 2'd2;
        count = 4'd8;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (cyc == 1) begin
        chk("busy_start", {63'd0, busy}, {63'd0, cn != 0});
        if (cn == 0)
          chk("no_access", {62'd0, rd_enable3, wr_enable3}, 0);
      end
      if (done) begin
        lat = cyc;
        chk("busy_at_done", {63'd0, busy}, 0);
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
      stall = stall_at(st, cyc);
    end
    start = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    chk("done_pulse", {63'd0, done}, 0);
    chk("sb_empty", 64'(sb.size()), 0);
    sb.delete();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]    ph;
    logic [NQ:0]   cn;
    int            pat;
    bit            st;
    int            extra;
    int            lat;
    bit            chk_m0;
    logic [MW-1:0] m0;
  } vec_t;

  vec_t vt[10];

  initial begin
    int lat;
    int seen;
    wr_t e;

    vt[0] = '{2'd1, 4'd1, 1, 1'b0, 0, 5,  1'b1, {24'h0, 24'h400000}};
    vt[1] = '{2'd2, 4'd8, 0, 1'b0, 0, 26, 1'b0, '0};
    vt[2] = '{2'd3, 4'd1, 2, 1'b0, 0, 5,  1'b1, {24'h0, 24'h7FFFFF}};
    vt[3] = '{2'd1, 4'd1, 1, 1'b1, 0, 12, 1'b1, {24'h0, 24'h400000}};
    vt[4] = '{2'd0, 4'd0, 3, 1'b0, 0, 1,  1'b0, '0};
    vt[5] = '{2'd3, 4'd8, 3, 1'b0, 0, 26, 1'b0, '0};
    vt[6] = '{2'd1, 4'd8, 2, 1'b0, 0, 26, 1'b1, {24'h0, 24'h800000}};
    vt[7] = '{2'd2, 4'd7, 3, 1'b1, 0, 30, 1'b0, '0};
    vt[8] = '{2'd0, 4'd2, 3, 1'b0, 2, 8,  1'b0, '0};
    vt[9] = '{2'd2, 4'd8, 2, 1'b1, 0, 33, 1'b1, {24'h7FFFFF, 24'h0}};

    #1;
    chk("reset_outs",
        {28'd0, rd_enable3, rd_address3, wr_enable3, wr_address3,
         busy, done, 16'd0},
        0);
    chk("reset_data", {16'd0, write_amplitude3}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      load(vt[i].pat);
      run(vt[i].ph, vt[i].cn, vt[i].st, vt[i].extra, lat);
      chk($sformatf("latency_%0d", i), 64'(lat), 64'(vt[i].lat));
      if (vt[i].chk_m0)
        chk($sformatf("mem0_%0d", i), {16'd0, mem[0]}, {16'd0, vt[i].m0});
    end

    // Abort mid-sweep: reset lands while a read is being issued.
    load(3);
    for (int k = 0; k < 2; k++) begin
      e.a = NQ'(k);
      e.d = rot_ref(2'd0, mem[k]);
      sb.push_back(e);
    end
    phase = 2'd0;
    count = 4'd8;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("pre_abort_rd", {63'd0, rd_enable3}, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_outs",
        {28'd0, rd_enable3, rd_address3, wr_enable3, wr_address3,
         busy, done, 16'd0},
        0);
    chk("abort_data", {16'd0, write_amplitude3}, 0);
    chk("abort_sb", 64'(sb.size()), 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | int'(done) | int'(busy);
    end
    chk("no_done_after_abort", 64'(seen), 0);
    @(posedge clk);
    #1;

`ifdef AMP_ZERO_SKIP_EN
    load(4);
    run(2'd0, 4'd4, 1'b0, 0, lat);
    chk("skip_latency", 64'(lat), 14);
    chk("nonzero_count", {60'd0, nonzero_count}, 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/amplitude_phase_sweep.md
Name: amplitude_phase_sweep

Overview:
- Read-modify-write engine on the amplitude RAM controller's port 3, the nonstabilizer phase-shift update channel.
- After a nonstabilizer gate, walks amplitude locations 0..count-1.
- Each location: read the stored complex amplitude, multiply by a Clifford phase (1, i, -1, -i), write the result back to the same address.
- Feeds rd_address3/rd_enable3 and wr_address3/wr_enable3/write_amplitude3. Consumes read_amplitude.

Parameters:
- num_qubit, 3, address width; RAM depth 2^num_qubit
- complex_bit, 24, width of each real/imag component (two's complement)
- fp_bit, 22, fractional bits per component (format only; no rescaling in this block)
- mem_width, 2*complex_bit, amplitude word width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begin sweep
- phase  in  2  phase code, sampled on start: 0 = x1, 1 = xi, 2 = x-1, 3 = x-i
- count  in  num_qubit+1  number of locations to sweep (0..2^num_qubit), sampled on start
- stall  in  1  a higher-priority requester owns the RAM this cycle (wr_enable0/1/2, rd_enable1/2)
- read_amplitude  in  mem_width  RAM read data, {real, imag}, real in upper half
- rd_enable3  out  1  read request
- rd_address3  out  num_qubit  read address
- wr_enable3  out  1  write request
- wr_address3  out  num_qubit  write address
- write_amplitude3  out  mem_width  rotated amplitude
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at sweep completion
- nonzero_count  out  num_qubit+1  present only with the optional feature

Behaviour:
- Reset: all outputs 0; state IDLE; pointer 0; latched phase/count 0.
- Reset is asynchronous. Asserting rst_n low mid-sweep aborts at once, with no done pulse. A partially swept RAM is left as is.
- RAM read latency is 1 cycle: data for the address presented at edge N is valid on read_amplitude during cycle N+1.
- State IDLE:
  - start=1, count=0: done=1 next cycle; busy stays 0.
  - start=1, count>0: latch phase and count, ptr=0, go to READ.
  - start while busy is ignored.
- State READ:
  - stall=1: outputs deasserted; hold.
  - stall=0: rd_enable3=1, rd_address3=ptr; go to CAPT.
- State CAPT: register read_amplitude into the data register regardless of stall; go to WRITE.
- State WRITE:
  - stall=1: wr_enable3=0; hold data.
  - stall=0: wr_enable3=1, wr_address3=ptr, write_amplitude3=rot(data).
  - Then if ptr==count-1, go to DONE; else ptr++ and go to READ.
- State DONE: done=1 for one cycle, busy=0, go to IDLE.
- busy=1 in READ, CAPT and WRITE.
- Throughput: 3 cycles per location without stalls. Sweep latency from start to done is 3*count+2 cycles.
- Rotation, with re/im as complex_bit signed values:
  - x1: (re, im)
  - xi: (-im, re)
  - x-1: (-re, -im)
  - x-i: (im, -re)
- Negation saturates: -(-2^(complex_bit-1)) gives 2^(complex_bit-1)-1. There is no other arithmetic.
- rd_enable3 and wr_enable3 are never high in the same cycle.
- Output addresses and data are 0 when the matching enable is 0.
- count=2^num_qubit: ptr covers the full range, and the last-location compare uses num_qubit+1-bit arithmetic.

Optional Feature:
- Macro: AMP_ZERO_SKIP_EN
- Defined:
  - In WRITE, if data==0 (both components zero), skip the write: wr_enable3 stays 0 and the state advances immediately, independent of stall.
  - nonzero_count counts locations with nonzero data in the current sweep. It clears on an accepted start and holds after done.
- Undefined: every location is written; the nonzero_count port is absent.

Test Plan:
- Reset, then start with phase=1, count=1; RAM[0]=(1.0, 0), i.e. real=0x400000, imag=0 -> one write to address 0 with (0, 0x400000); done on cycle 5 after start.
- phase=2, count=8, RAM[k]=(k<<22, -k<<22) -> each word negated; 8 writes at addresses 0..7 in order; done 26 cycles after start.
- phase=3, RAM[0]=(0x800000, 0) -> written (0, 0x7FFFFF), confirming saturation.
- stall high for 4 cycles during READ and 3 cycles during WRITE -> no enables while stalled; same final data; latency grows by exactly 7 cycles.
- count=0 -> done the next cycle, no RAM access. Second start while busy -> ignored. rst_n low mid-sweep -> all outputs 0 immediately, no done.
- AMP_ZERO_SKIP_EN with RAM = {1.0, 0, 0, -1.0}, count=4, phase=0 -> writes only at addresses 0 and 3; nonzero_count=2.
